// File: rtl/bk_div_pkg.sv
// Shared constants and state encoding for the 4-bit sequential divider.
package bk_div_pkg;
    localparam int DIV_W = 4;
    localparam int SUB_W = DIV_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_W-1:0] DBZ_QUOT = 4'hF;
endpackage

// File: rtl/bk5_sub.sv
// 5-bit subtractor a - b as a + ~b + 1 on a Brent-Kung prefix tree.
module bk5_sub
    import bk_div_pkg::*;
(
    input  logic [SUB_W-1:0] a,
    input  logic [SUB_W-1:0] b,
    output logic [SUB_W-1:0] diff,
    output logic             cout
);
    logic [SUB_W-1:0] g, p, c;
    logic g0c, g10, g32, p32, g30, g20, g40;

    for (genvar i = 0; i < SUB_W; i++) begin : g_gp
        assign g[i] = a[i] & ~b[i];
        assign p[i] = a[i] ^ ~b[i];
    end

    // Carry-in of 1 folds into bit 0's group generate.
    assign g0c = g[0] | p[0];

    // Up-sweep
    assign g10 = g[1] | (p[1] & g0c);
    assign g32 = g[3] | (p[3] & g[2]);
    assign p32 = p[3] & p[2];
    assign g30 = g32 | (p32 & g10);

    // Down-sweep
    assign g20 = g[2] | (p[2] & g10);
    assign g40 = g[4] | (p[4] & g30);

    assign c    = {g30, g20, g10, g0c, 1'b1};
    assign diff = p ^ c;
    assign cout = g40;
endmodule

// File: rtl/bk4_div.sv
// 4-bit unsigned restoring divider, one quotient bit per clock.
module bk4_div
    import bk_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             div_by_zero
);
    state_t           state, state_nxt;
    logic [DIV_W-1:0] q, d;
    logic [SUB_W-1:0] r, s, t;
    logic [1:0]       cnt;
    logic             dbz, nb, accept;
    logic             unused_r_msb;

    assign s = {r[DIV_W-1:0], q[DIV_W-1]};

    bk5_sub u_sub (
        .a    (s),
        .b    ({1'b0, d}),
        .diff (t),
        .cout (nb)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN:     if (cnt == 2'd0) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            r     <= '0;
            d     <= '0;
            cnt   <= '0;
            dbz   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (divisor != '0) begin
                    q   <= dividend;
                    r   <= '0;
                    d   <= divisor;
                    cnt <= 2'd3;
                    dbz <= 1'b0;
                end else begin
                    q   <= DBZ_QUOT;
                    r   <= {1'b0, dividend};
                    dbz <= 1'b1;
                end
            end else if (state == RUN) begin
                r <= nb ? t : s;
                q <= {q[DIV_W-2:0], nb};
                if (cnt != 2'd0) cnt <= cnt - 2'd1;
            end
        end
    end

    // A completed step always leaves R < D, so the top bit never reaches the output.
    assign unused_r_msb = r[DIV_W];

    assign busy        = (state == RUN);
    assign done        = (state == DONE);
    assign quotient    = q;
    assign remainder   = r[DIV_W-1:0];
    assign div_by_zero = dbz;
endmodule

// File: tb/tb_bk4_div.sv
// Directed and exhaustive checks of bk4_div against hand values and a reference model.
module tb_bk4_div;
    logic       clk = 1'b0;
    logic       rst, start;
    logic [3:0] dividend, divisor;
    logic       busy, done, div_by_zero;
    logic [3:0] quotient, remainder;
    int         tests = 0;
    int         fails = 0;

    bk4_div dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
        chk({tag, "_done"}, {7'd0, done}, 8'd0);
        chk({tag, "_quot"}, {4'd0, quotient}, 8'd0);
        chk({tag, "_rem"},  {4'd0, remainder}, 8'd0);
        chk({tag, "_dbz"},  {7'd0, div_by_zero}, 8'd0);
    endtask

    // Starts an op in the current cycle and returns in its DONE cycle with start low.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er, input logic edz);
        start = 1'b1; dividend = a; divisor = b;
        tick();
        start = 1'b0; dividend = 4'hx; divisor = 4'hx;
        if (b != 4'd0) begin
            for (int i = 0; i < 4; i++) begin
                chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
                chk({tag, "_nodone"}, {7'd0, done}, 8'd0);
                tick();
            end
        end
        chk({tag, "_done"}, {7'd0, done}, 8'd1);
        chk({tag, "_idle"}, {7'd0, busy}, 8'd0);
        chk({tag, "_quot"}, {4'd0, quotient}, {4'd0, eq});
        chk({tag, "_rem"},  {4'd0, remainder}, {4'd0, er});
        chk({tag, "_dbz"},  {7'd0, div_by_zero}, {7'd0, edz});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
        tick(); tick();
        chk_idle_zero("reset");
        rst = 1'b0;
        tick();

        run_op("d13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
        tick();
        chk("d13_3_strobe", {7'd0, done}, 8'd0);
        chk("d13_3_hold_q", {4'd0, quotient}, 8'd4);

        // Back-to-back with start issued in each DONE cycle.
        run_op("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
        run_op("d2_9",  4'd2,  4'd9, 4'd0,  4'd2, 1'b0);
        run_op("d9_9",  4'd9,  4'd9, 4'd1,  4'd0, 1'b0);
        tick();

        run_op("d7_0", 4'd7, 4'd0, 4'd15, 4'd7, 1'b1);
        tick();
        chk("d7_0_dbz_hold", {7'd0, div_by_zero}, 8'd1);
        run_op("d6_4", 4'd6, 4'd4, 4'd1, 4'd2, 1'b0);
        tick();

        // Start pulse mid-RUN must be ignored.
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        tick();
        for (int i = 0; i < 4; i++) begin
            start = (i == 1); dividend = 4'd1; divisor = 4'd1;
            chk("midrun_busy", {7'd0, busy}, 8'd1);
            chk("midrun_nodone", {7'd0, done}, 8'd0);
            tick();
        end
        start = 1'b0;
        chk("midrun_done", {7'd0, done}, 8'd1);
        chk("midrun_quot", {4'd0, quotient}, 8'd4);
        chk("midrun_rem",  {4'd0, remainder}, 8'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrun_single_done", {7'd0, done}, 8'd0);
        end

        // Reset in the second RUN cycle aborts the op.
        start = 1'b1; dividend = 4'd14; divisor = 4'd5;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_zero("abort");
        for (int i = 0; i < 5; i++) begin
            chk("abort_nodone", {7'd0, done}, 8'd0);
            tick();
        end
        run_op("d14_5", 4'd14, 4'd5, 4'd2, 4'd4, 1'b0);
        tick();

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0)
                    run_op("sweep", 4'(a), 4'd0, 4'hF, 4'(a), 1'b1);
                else
                    run_op("sweep", 4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
